// File: rtl/cc_pkg.sv
// Shared types and defaults for the CPU-side watchdog/reset slice.
package cc_pkg;

  typedef enum logic [1:0] {
    POR  = 2'd0,
    RUN  = 2'd1,
    TRIP = 2'd2,
    HOLD = 2'd3
  } state_e;

  localparam logic [15:0] WDOG_ADDR_DEF = 16'h9600;
  localparam logic [15:0] ADDR_MASK_DEF = 16'hFF80;

  // Masked address compare: only bits set in mask take part.
  function automatic logic addr_hit(input logic [15:0] addr,
                                    input logic [15:0] base,
                                    input logic [15:0] mask);
    return ((addr ^ base) & mask) == 16'h0000;
  endfunction

endpackage

// File: rtl/wdog_addr_decode.sv
// CPU write-strobe decoder: masked address match, registered one-clk active-low strobe.
module wdog_addr_decode
  import cc_pkg::*;
#(
  parameter logic [15:0] ADDR = WDOG_ADDR_DEF,
  parameter logic [15:0] MASK = ADDR_MASK_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_en,
  input  logic        i_force,
  input  logic        cpu_ce,
  input  logic        cpu_wr,
  input  logic [15:0] cpu_addr,
  output logic        o_strobe_n
);

  logic w_hit;
  logic r_strobe_n;

  assign w_hit = addr_hit(cpu_addr, ADDR, MASK);

  // i_force holds the strobe low continuously (watchdog clear while CPU is in reset).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_strobe_n <= 1'b0;
    end else if (i_force) begin
      r_strobe_n <= 1'b0;
    end else begin
      r_strobe_n <= ~(i_en & cpu_ce & cpu_wr & w_hit);
    end
  end

  assign o_strobe_n = r_strobe_n;

endmodule

// File: rtl/wdog_reset_ctrl.sv
// CPU-side watchdog partner: kick decode, trip detection, stretched CPU reset, trip counter.
module wdog_reset_ctrl
  import cc_pkg::*;
#(
  parameter logic [15:0] WDOG_ADDR   = WDOG_ADDR_DEF,
  parameter logic [15:0] ADDR_MASK   = ADDR_MASK_DEF,
  parameter int          HOLD_CYCLES = 16,
  parameter int          CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cpu_ce,
  input  logic [15:0]      cpu_addr,
  input  logic             cpu_wr,
  input  logic             wdog_dis_sw,
  input  logic             WDRESETn,
  output logic             WDOGn,
  output logic             WDISn,
  output logic             cpu_reset_n,
  output logic             wd_trip,
  output logic [CNT_W-1:0] trip_count
);

  localparam int              HC_W      = $clog2(HOLD_CYCLES) + 1;
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_CYCLES - 1);

  state_e            r_state;
  state_e            w_state_next;
  logic [HC_W-1:0]   r_hold_cnt;
  logic [HC_W-1:0]   w_hold_next;
  logic              r_cpu_reset_n;
  logic              r_wd_trip;
  logic              r_wdis_n;
  logic [CNT_W-1:0]  r_trip_count;
  logic              w_wdog_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= POR;
      r_hold_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_hold_cnt <= w_hold_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_hold_next  = r_hold_cnt;
    case (r_state)
      POR: begin
        if (cpu_ce) begin
          if (r_hold_cnt == HOLD_LAST) begin
            w_state_next = RUN;
            w_hold_next  = '0;
          end else begin
            w_hold_next = r_hold_cnt + HC_W'(1);
          end
        end
      end
      RUN: begin
        if (!WDRESETn) begin
          w_state_next = TRIP;
        end
      end
      TRIP: begin
        w_state_next = HOLD;
        w_hold_next  = '0;
      end
      HOLD: begin
        // Saturate at the terminal count until the watchdog releases its output.
        if (cpu_ce) begin
          if (r_hold_cnt == HOLD_LAST) begin
            if (WDRESETn) begin
              w_state_next = RUN;
              w_hold_next  = '0;
            end
          end else begin
            w_hold_next = r_hold_cnt + HC_W'(1);
          end
        end
      end
      default: begin
        w_state_next = POR;
        w_hold_next  = '0;
      end
    endcase
  end

  // Outputs track the state being entered, so they are aligned with r_state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cpu_reset_n <= 1'b0;
      r_wd_trip     <= 1'b0;
      r_wdis_n      <= 1'b1;
      r_trip_count  <= '0;
    end else begin
      r_cpu_reset_n <= (w_state_next == RUN);
      r_wd_trip     <= (w_state_next == TRIP);
      r_wdis_n      <= (r_state == POR) ? 1'b1 : ~wdog_dis_sw;
      if ((w_state_next == TRIP) && (r_trip_count != {CNT_W{1'b1}})) begin
        r_trip_count <= r_trip_count + CNT_W'(1);
      end
    end
  end

  wdog_addr_decode #(
    .ADDR (WDOG_ADDR),
    .MASK (ADDR_MASK)
  ) u_kick_decode (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_en       (r_state == RUN),
    .i_force    (w_state_next != RUN),
    .cpu_ce     (cpu_ce),
    .cpu_wr     (cpu_wr),
    .cpu_addr   (cpu_addr),
    .o_strobe_n (w_wdog_n)
  );

  assign WDOGn       = w_wdog_n;
  assign WDISn       = r_wdis_n;
  assign cpu_reset_n = r_cpu_reset_n;
  assign wd_trip     = r_wd_trip;
  assign trip_count  = r_trip_count;

endmodule
